// File: rtl/multdiv_unit.sv
// Iterative MIPS mult/div unit with HI/LO registers; WIDTH iterations per operation.
// Optional MULTDIV_SIGNED_EN adds the signed_op port for signed mult/div.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isdiv,
`ifdef MULTDIV_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [1:0]       hilo,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_e               state_q;
  logic [CNTW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q;
  logic [WIDTH-1:0]     hi_q, lo_q, hi_d, lo_d;
  logic                 div_q, neg_res_q, neg_rem_q, divzero_q, done_q;

  logic                 sgn;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;

`ifdef MULTDIV_SIGNED_EN
  assign sgn = signed_op;
`else
  assign sgn = 1'b0;
`endif

  // Operands are reduced to magnitudes at start; signs are restored on the final write.
  assign a_mag = (sgn && srca[WIDTH-1]) ? -srca : srca;
  assign b_mag = (sgn && srcb[WIDTH-1]) ? -srcb : srcb;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[WIDTH];
    if (div_q)
      acc_d = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
    else
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    prod = neg_res_q ? -acc_d : acc_d;
    quot = neg_res_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

    if (div_q) begin
      // Divide by zero: the restoring loop leaves |srca| as remainder, which re-signs to srca.
      hi_d = rem;
      lo_d = divzero_q ? {WIDTH{1'b1}} : quot;
    end else begin
      hi_d = prod[2*WIDTH-1:WIDTH];
      lo_d = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= BUSY;
            cnt_q     <= '0;
            div_q     <= isdiv;
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
            opb_q     <= b_mag;
            neg_res_q <= sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_rem_q <= sgn & srca[WIDTH-1];
            divzero_q <= (srcb == '0);
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == BUSY);
  assign done        = done_q;
  assign dbg_state_o = state_q;
  assign stall       = busy && (start || hilo == 2'b10 || hilo == 2'b01);
  assign hilo_rdata  = (hilo == 2'b10) ? hi_q :
                       (hilo == 2'b01) ? lo_q : {WIDTH{1'b0}};

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed mult/div vectors, HI/LO reads checked by a
// queue-based monitor, plus latency, done-pulse, stall and reset-abort checks.
module tb_multdiv_unit;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         isdiv;
`ifdef MULTDIV_SIGNED_EN
  logic         signed_op;
`endif
  logic [W-1:0] srca, srcb;
  logic [1:0]   hilo;
  logic [W-1:0] hilo_rdata;
  logic         busy, stall, done, dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [W:0] exp_q[$];  // {expected hilo_rdata, expected stall} per read cycle

  multdiv_unit #(.WIDTH(W), .CNTW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .isdiv(isdiv),
`ifdef MULTDIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .srca(srca), .srcb(srcb), .hilo(hilo), .hilo_rdata(hilo_rdata),
    .busy(busy), .stall(stall), .done(done), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // monitor: every cycle that presents an mfhi/mflo read is compared against the queue
  always @(negedge clk) begin
    if (reset === 1'b1 && (hilo == 2'b10 || hilo == 2'b01)) begin
      logic [W:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_read", {31'b0, hilo_rdata, stall}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("hilo_rdata", {32'b0, hilo_rdata}, {32'b0, e[W:1]});
        check("stall", {63'b0, stall}, {63'b0, e[0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input logic [1:0] sel, input logic [W-1:0] exp_val);
    exp_q.push_back({exp_val, 1'b0});
    hilo = sel;
    tick();
    hilo = 2'b00;
  endtask

  task automatic run_op(input logic div, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int n;
    logic early_done;
    isdiv = div;
`ifdef MULTDIV_SIGNED_EN
    signed_op = sgn;
`else
    if (sgn) $display("note: signed vector skipped in unsigned build");
`endif
    srca  = a;
    srcb  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    early_done = 1'b0;
    while (busy && n < 100) begin
      if (done) early_done = 1'b1;
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(W));
    check("done_early", {63'b0, early_done}, 64'd0);
    check("done_pulse", {63'b0, done}, 64'd1);
    read_hilo(2'b10, exp_hi);
    check("done_clear", {63'b0, done}, 64'd0);
    read_hilo(2'b01, exp_lo);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    isdiv = 1'b0;
`ifdef MULTDIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    srca = 32'd1;
    srcb = 32'd1;
    hilo = 2'b01;
    #12;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_stall", {63'b0, stall}, 64'd0);
    check("rst_state", {63'b0, dbg_state}, 64'd0);
    check("rst_lo", {32'b0, hilo_rdata}, 64'd0);
    hilo  = 2'b00;
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    run_op(1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 32'd42);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);

    // mflo held across an operation: old LO while busy, new LO right after; second start ignored
    isdiv = 1'b0;
    srca  = 32'd3;
    srcb  = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    hilo  = 2'b01;
    for (int i = 0; i < W; i++) begin
      exp_q.push_back({32'h0FFF_FFFF, 1'b1});
      if (i == 5) begin
        start = 1'b1;
        srca  = 32'd9;
        srcb  = 32'd9;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    exp_q.push_back({32'd15, 1'b0});
    tick();
    hilo = 2'b00;
    check("ignored_start_busy", {63'b0, busy}, 64'd0);
    read_hilo(2'b10, 32'd0);

    // asynchronous reset in the middle of an operation
    srca  = 32'd1000;
    srcb  = 32'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    hilo = 2'b10;
    #1;
    check("abort_hi", {32'b0, hilo_rdata}, 64'd0);
    hilo = 2'b01;
    #1;
    check("abort_lo", {32'b0, hilo_rdata}, 64'd0);
    hilo = 2'b00;
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (i == 3) reset = 1'b1;
        tick();
        if (done) seen_done = 1'b1;
      end
      check("abort_no_done", {63'b0, seen_done}, 64'd0);
    end
    run_op(1'b0, 1'b0, 32'd12, 32'd11, 32'd0, 32'd132);

`ifdef MULTDIV_SIGNED_EN
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
`endif

    tick();
    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
